// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, lamp indices and helpers for the intersection controller. Rev 1.0
`default_nettype none

package traffic_pkg;

   typedef enum logic [1:0] {
      ST_ALL_RED = 2'd0,
      ST_WALK    = 2'd1,
      ST_GREEN   = 2'd2,
      ST_YELLOW  = 2'd3
   } state_t;

   localparam int LAMP_RED    = 0;
   localparam int LAMP_YELLOW = 1;
   localparam int LAMP_GREEN  = 2;

   // Minimum one bit so a 1-phase build still has a legal index port.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic logic [2:0] served_lamps(input state_t s);
      logic [2:0] l;
      l = 3'b000;
      case (s)
         ST_GREEN:  l[LAMP_GREEN]  = 1'b1;
         ST_YELLOW: l[LAMP_YELLOW] = 1'b1;
         default:   l[LAMP_RED]    = 1'b1;
      endcase
      return l;
   endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_phase_select.sv
// traffic_phase_select: round-robin demand finder, searching from phase+1 with the current phase last. Rev 1.0
`default_nettype none

module traffic_phase_select
   import traffic_pkg::*;
#(
   parameter  int NUM_PHASES = 4,
   localparam int PW         = clog2(NUM_PHASES)
) (
   input  logic [PW-1:0]         phase,
   input  logic [NUM_PHASES-1:0] demand,
   output logic [PW-1:0]         next_phase
);

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
      return PW'((int'(p) + k) % NUM_PHASES);
   endfunction

   // With no demand anywhere the default rotates to phase+1.
   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      found      = 1'b0;
      idx        = '0;
      next_phase = wrap_add(phase, 1);
      for (int k = 1; k <= NUM_PHASES; k++) begin
         idx = wrap_add(phase, k);
         if (!found && demand[idx]) begin
            next_phase = idx;
            found      = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: N-phase signal controller with actuated green, ped walk and all-red clearance. Rev 1.0
// Optional emergency preemption enabled by defining TRAFFIC_PREEMPT_EN.
`default_nettype none

module traffic_intersection_ctrl
   import traffic_pkg::*;
#(
   parameter  int NUM_PHASES = 4,
   parameter  int TIMER_W    = 8,
   parameter  int GREEN_MIN  = 10,
   parameter  int GREEN_MAX  = 30,
   parameter  int YELLOW_T   = 3,
   parameter  int ALLRED_T   = 2,
   parameter  int WALK_T     = 6,
   localparam int PW         = clog2(NUM_PHASES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic [NUM_PHASES-1:0] veh_detect,
   input  logic [NUM_PHASES-1:0] ped_req,
`ifdef TRAFFIC_PREEMPT_EN
   input  logic                  preempt,
   input  logic [PW-1:0]         preempt_phase,
`endif
   output logic [NUM_PHASES-1:0] red,
   output logic [NUM_PHASES-1:0] yellow,
   output logic [NUM_PHASES-1:0] green,
   output logic [NUM_PHASES-1:0] walk,
   output logic [NUM_PHASES-1:0] ped_pending,
   output logic [PW-1:0]         phase
);

   localparam logic [TIMER_W-1:0] GMIN_END  = TIMER_W'(GREEN_MIN - 1);
   localparam logic [TIMER_W-1:0] GMAX_END  = TIMER_W'(GREEN_MAX - 1);
   localparam logic [TIMER_W-1:0] YEL_END   = TIMER_W'(YELLOW_T - 1);
   localparam logic [TIMER_W-1:0] AR_END    = TIMER_W'(ALLRED_T - 1);
   localparam logic [TIMER_W-1:0] WALK_END  = TIMER_W'(WALK_T - 1);
   localparam logic [TIMER_W-1:0] TIMER_SAT = '1;

   state_t                  state;
   logic [TIMER_W-1:0]      timer;
   logic [NUM_PHASES-1:0]   pending;
   logic                    started;
   logic [PW-1:0]           search_base;
   logic [PW-1:0]           next_phase;

   logic                    preempt_rise;
   logic                    preempt_hold;
   logic                    preempt_level;
   logic [PW-1:0]           preempt_target;

   // Before the first service the search starts one below phase 0 so phase 0 is served first.
   assign search_base = started ? phase : PW'(NUM_PHASES - 1);

   traffic_phase_select #(
      .NUM_PHASES (NUM_PHASES)
   ) u_select (
      .phase      (search_base),
      .demand     (veh_detect | pending),
      .next_phase (next_phase)
   );

`ifdef TRAFFIC_PREEMPT_EN
   logic preempt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) preempt_q <= 1'b0;
      else     preempt_q <= preempt;
   end

   assign preempt_level  = preempt;
   assign preempt_target = preempt_phase;
   assign preempt_hold   = preempt && (state == ST_GREEN) && (phase == preempt_phase);
   assign preempt_rise   = preempt && !preempt_q && !preempt_hold;
`else
   assign preempt_level  = 1'b0;
   assign preempt_target = '0;
   assign preempt_hold   = 1'b0;
   assign preempt_rise   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_ALL_RED;
         phase   <= '0;
         timer   <= '0;
         pending <= '0;
         started <= 1'b0;
      end else begin
         pending <= pending | ped_req;
         if (tick && (timer != TIMER_SAT)) timer <= timer + 1'b1;
         case (state)
            ST_ALL_RED: begin
               if (tick && (timer == AR_END)) begin
                  timer   <= '0;
                  started <= 1'b1;
                  if (preempt_level) begin
                     phase <= preempt_target;
                     state <= ST_GREEN;
                  end else begin
                     phase <= next_phase;
                     if (pending[next_phase]) begin
                        state               <= ST_WALK;
                        pending[next_phase] <= 1'b0;
                     end else begin
                        state <= ST_GREEN;
                     end
                  end
               end
            end
            ST_WALK: begin
               if (preempt_rise) begin
                  state <= ST_ALL_RED;
                  timer <= '0;
               end else if (tick && (timer == WALK_END)) begin
                  state <= ST_GREEN;
                  timer <= '0;
               end
            end
            ST_GREEN: begin
               // Saturating timer plus >= compares keep a long preempt hold exiting cleanly.
               if (preempt_rise) begin
                  state <= ST_YELLOW;
                  timer <= '0;
               end else if (!preempt_hold && tick &&
                            (((timer >= GMIN_END) && !veh_detect[phase]) || (timer >= GMAX_END))) begin
                  state <= ST_YELLOW;
                  timer <= '0;
               end
            end
            default: begin
               if (tick && (timer == YEL_END)) begin
                  state <= ST_ALL_RED;
                  timer <= '0;
               end
            end
         endcase
      end
   end

   always_comb begin
      logic [2:0] lamps;
      lamps         = served_lamps(state);
      red           = '1;
      yellow        = '0;
      green         = '0;
      walk          = '0;
      red[phase]    = lamps[LAMP_RED];
      yellow[phase] = lamps[LAMP_YELLOW];
      green[phase]  = lamps[LAMP_GREEN];
      walk[phase]   = (state == ST_WALK);
   end

   assign ped_pending = pending;

endmodule

`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl: directed self-checking bench for the intersection controller. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_traffic_intersection_ctrl;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         tick;
   logic [N-1:0] veh_detect;
   logic [N-1:0] ped_req;
   logic [N-1:0] red;
   logic [N-1:0] yellow;
   logic [N-1:0] green;
   logic [N-1:0] walk;
   logic [N-1:0] ped_pending;
   logic [1:0]   phase;
`ifdef TRAFFIC_PREEMPT_EN
   logic         preempt;
   logic [1:0]   preempt_phase;
`endif

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   traffic_intersection_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .veh_detect    (veh_detect),
      .ped_req       (ped_req),
`ifdef TRAFFIC_PREEMPT_EN
      .preempt       (preempt),
      .preempt_phase (preempt_phase),
`endif
      .red           (red),
      .yellow        (yellow),
      .green         (green),
      .walk          (walk),
      .ped_pending   (ped_pending),
      .phase         (phase)
   );

   // 0 all-red, 1 walk, 2 green, 3 yellow, decoded from the lamp outputs.
   function automatic int kind();
      if (|green)  return 2;
      if (|yellow) return 3;
      if (|walk)   return 1;
      return 0;
   endfunction

   task automatic count_kind(input int k, output int len);
      len = 0;
      while (kind() == k && len < 500) begin
         len++;
         @(negedge clk);
      end
   endtask

   task automatic wait_until(input int k, input int p, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (kind() == k && int'(phase) == p) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst        = 1'b1;
      tick       = 1'b1;
      veh_detect = '0;
      ped_req    = '0;
`ifdef TRAFFIC_PREEMPT_EN
      preempt       = 1'b0;
      preempt_phase = '0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      int len;
      rst = 1'b1; tick = 1'b1; veh_detect = '0; ped_req = '0;
`ifdef TRAFFIC_PREEMPT_EN
      preempt = 1'b0; preempt_phase = '0;
`endif
      repeat (2) @(negedge clk);
      checks++; if (red !== 4'hF)         $display("FAIL reset_red got %h exp f", red);            else passed++;
      checks++; if (yellow !== 4'h0)      $display("FAIL reset_yellow got %h exp 0", yellow);      else passed++;
      checks++; if (green !== 4'h0)       $display("FAIL reset_green got %h exp 0", green);        else passed++;
      checks++; if (walk !== 4'h0)        $display("FAIL reset_walk got %h exp 0", walk);          else passed++;
      checks++; if (ped_pending !== 4'h0) $display("FAIL reset_pending got %h exp 0", ped_pending); else passed++;
      checks++; if (phase !== 2'd0)       $display("FAIL reset_phase got %0d exp 0", phase);       else passed++;
      rst = 1'b0;
      count_kind(0, len);
      checks++; if (len != 2) $display("FAIL reset_allred_len got %0d exp 2", len); else passed++;
   endtask

   task automatic test_rotation();
      int len;
      int exp_p;
      apply_reset();
      count_kind(0, len);
      for (int i = 0; i < 5; i++) begin
         exp_p = i % 4;
         checks++; if (int'(phase) != exp_p) $display("FAIL rot_phase got %0d exp %0d", phase, exp_p); else passed++;
         checks++; if (green !== 4'(1 << exp_p)) $display("FAIL rot_green got %h exp %h", green, 4'(1 << exp_p)); else passed++;
         count_kind(2, len);
         checks++; if (len != 10) $display("FAIL rot_green_len got %0d exp 10", len); else passed++;
         checks++; if (yellow !== 4'(1 << exp_p)) $display("FAIL rot_yellow got %h exp %h", yellow, 4'(1 << exp_p)); else passed++;
         count_kind(3, len);
         checks++; if (len != 3) $display("FAIL rot_yellow_len got %0d exp 3", len); else passed++;
         checks++; if (red !== 4'hF) $display("FAIL rot_allred_red got %h exp f", red); else passed++;
         count_kind(0, len);
         checks++; if (len != 2) $display("FAIL rot_allred_len got %0d exp 2", len); else passed++;
      end
   endtask

   task automatic test_green_cap();
      int len;
      bit ok;
      apply_reset();
      veh_detect = 4'b0010;
      wait_until(2, 1, ok);
      checks++; if (!ok) $display("FAIL cap_reach_green1 got timeout exp green1"); else passed++;
      count_kind(2, len);
      checks++; if (len != 30) $display("FAIL cap_green_len got %0d exp 30", len); else passed++;
      checks++; if (yellow !== 4'b0010) $display("FAIL cap_yellow got %h exp 2", yellow); else passed++;
      veh_detect = '0;
   endtask

   task automatic test_veh_drop();
      int len;
      bit ok;
      apply_reset();
      veh_detect = 4'b0010;
      wait_until(2, 1, ok);
      checks++; if (!ok) $display("FAIL drop_reach_green1 got timeout exp green1"); else passed++;
      repeat (15) @(negedge clk);
      veh_detect = '0;
      count_kind(2, len);
      checks++; if (len != 1) $display("FAIL drop_green_tail got %0d exp 1", len); else passed++;
      checks++; if (yellow !== 4'b0010) $display("FAIL drop_yellow got %h exp 2", yellow); else passed++;
   endtask

   task automatic test_ped_walk();
      int len;
      bit ok;
      apply_reset();
      wait_until(2, 0, ok);
      checks++; if (!ok) $display("FAIL ped_reach_green0 got timeout exp green0"); else passed++;
      ped_req = 4'b0100;
      @(negedge clk);
      ped_req = '0;
      checks++; if (ped_pending !== 4'b0100) $display("FAIL ped_latched got %h exp 4", ped_pending); else passed++;
      count_kind(2, len);
      checks++; if (len != 9) $display("FAIL ped_green0_rest got %0d exp 9", len); else passed++;
      count_kind(3, len);
      count_kind(0, len);
      checks++; if (len != 2) $display("FAIL ped_allred_len got %0d exp 2", len); else passed++;
      checks++; if (walk !== 4'b0100) $display("FAIL ped_walk got %h exp 4", walk); else passed++;
      checks++; if (red !== 4'hF) $display("FAIL ped_walk_red got %h exp f", red); else passed++;
      checks++; if (phase !== 2'd2) $display("FAIL ped_phase got %0d exp 2", phase); else passed++;
      checks++; if (ped_pending !== 4'h0) $display("FAIL ped_cleared got %h exp 0", ped_pending); else passed++;
      count_kind(1, len);
      checks++; if (len != 6) $display("FAIL ped_walk_len got %0d exp 6", len); else passed++;
      checks++; if (green !== 4'b0100) $display("FAIL ped_green2 got %h exp 4", green); else passed++;
      count_kind(2, len);
      checks++; if (len != 10) $display("FAIL ped_green2_len got %0d exp 10", len); else passed++;
   endtask

   task automatic test_ped_relatch();
      int len;
      bit ok;
      apply_reset();
      wait_until(2, 0, ok);
      checks++; if (!ok) $display("FAIL relatch_reach_green0 got timeout exp green0"); else passed++;
      ped_req = 4'b0100;
      @(negedge clk);
      ped_req = '0;
      count_kind(2, len);
      count_kind(3, len);
      @(negedge clk);
      ped_req = 4'b0100;
      @(negedge clk);
      ped_req = '0;
      checks++; if (walk !== 4'b0100) $display("FAIL relatch_walk_entry got %h exp 4", walk); else passed++;
      checks++; if (ped_pending !== 4'h0) $display("FAIL relatch_entry_cleared got %h exp 0", ped_pending); else passed++;
      ped_req = 4'b0100;
      @(negedge clk);
      ped_req = '0;
      checks++; if (ped_pending !== 4'b0100) $display("FAIL relatch_next_cycle got %h exp 4", ped_pending); else passed++;
      count_kind(1, len);
      count_kind(2, len);
      count_kind(3, len);
      count_kind(0, len);
      checks++; if (phase !== 2'd2) $display("FAIL relatch_revisit_phase got %0d exp 2", phase); else passed++;
      checks++; if (walk !== 4'b0100) $display("FAIL relatch_revisit_walk got %h exp 4", walk); else passed++;
   endtask

   task automatic test_reset_mid_yellow();
      int len;
      bit ok;
      apply_reset();
      wait_until(2, 3, ok);
      checks++; if (!ok) $display("FAIL midrst_reach_green3 got timeout exp green3"); else passed++;
      ped_req = 4'b0001;
      @(negedge clk);
      ped_req = '0;
      wait_until(3, 3, ok);
      checks++; if (!ok) $display("FAIL midrst_reach_yellow3 got timeout exp yellow3"); else passed++;
      checks++; if (ped_pending !== 4'b0001) $display("FAIL midrst_pre_pending got %h exp 1", ped_pending); else passed++;
      #2 rst = 1'b1;
      #1;
      checks++; if (red !== 4'hF)         $display("FAIL midrst_red got %h exp f", red);            else passed++;
      checks++; if (yellow !== 4'h0)      $display("FAIL midrst_yellow got %h exp 0", yellow);      else passed++;
      checks++; if (walk !== 4'h0)        $display("FAIL midrst_walk got %h exp 0", walk);          else passed++;
      checks++; if (ped_pending !== 4'h0) $display("FAIL midrst_pending got %h exp 0", ped_pending); else passed++;
      checks++; if (phase !== 2'd0)       $display("FAIL midrst_phase got %0d exp 0", phase);       else passed++;
      @(negedge clk);
      rst = 1'b0;
      count_kind(0, len);
      checks++; if (len != 2) $display("FAIL midrst_allred_len got %0d exp 2", len); else passed++;
      checks++; if (green !== 4'b0001) $display("FAIL midrst_green0 got %h exp 1", green); else passed++;
   endtask

`ifdef TRAFFIC_PREEMPT_EN
   task automatic test_preempt();
      int len;
      bit ok;
      apply_reset();
      wait_until(2, 0, ok);
      checks++; if (!ok) $display("FAIL pre_reach_green0 got timeout exp green0"); else passed++;
      repeat (3) @(negedge clk);
      preempt       = 1'b1;
      preempt_phase = 2'd2;
      @(negedge clk);
      checks++; if (yellow !== 4'b0001) $display("FAIL pre_yellow0 got %h exp 1", yellow); else passed++;
      count_kind(3, len);
      checks++; if (len != 3) $display("FAIL pre_yellow_len got %0d exp 3", len); else passed++;
      count_kind(0, len);
      checks++; if (len != 2) $display("FAIL pre_allred_len got %0d exp 2", len); else passed++;
      checks++; if (green !== 4'b0100) $display("FAIL pre_green2 got %h exp 4", green); else passed++;
      repeat (50) @(negedge clk);
      checks++; if (green !== 4'b0100) $display("FAIL pre_green2_held got %h exp 4", green); else passed++;
      preempt = 1'b0;
      @(negedge clk);
      checks++; if (yellow !== 4'b0100) $display("FAIL pre_release_yellow got %h exp 4", yellow); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_rotation();
      test_green_cap();
      test_veh_drop();
      test_ped_walk();
      test_ped_relatch();
      test_reset_mid_yellow();
`ifdef TRAFFIC_PREEMPT_EN
      test_preempt();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
